// File: rtl/led_effect_ctrl.sv
// LED effect sequencer: short press steps the effect mode, long press toggles run/pause.
// Optional macro PAUSE_BLINK_EN makes the paused pattern blink instead of freezing steady.
module led_effect_ctrl #(
    parameter int unsigned TICK_DIV   = 500000,
    parameter int unsigned STEP_TICKS = 20,
    parameter int unsigned LONG_TICKS = 100
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       db,
    output logic [7:0] led,
    output logic [1:0] mode,
    output logic       running,
    output logic       ev_short,
    output logic       ev_long
);

    localparam int unsigned TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int unsigned SW = (STEP_TICKS > 1) ? $clog2(STEP_TICKS) : 1;
    localparam int unsigned HW = (LONG_TICKS > 1) ? $clog2(LONG_TICKS) : 1;

    localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
    localparam logic [SW-1:0] STEP_LAST = SW'(STEP_TICKS - 1);
    localparam logic [HW-1:0] HOLD_LAST = HW'(LONG_TICKS - 1);

    typedef enum logic [1:0] {StIdle, StPressed, StLongHeld} state_t;

    state_t        state_q;
    logic [TW-1:0] tick_cnt_q;
    logic [SW-1:0] step_cnt_q;
    logic [HW-1:0] hold_cnt_q;
    logic          db_q;
    logic          dir_left_q;
    logic [7:0]    pattern_q;

    logic       tick;
    logic       press;
    logic       short_acc;
    logic       long_acc;
    logic [1:0] next_mode;
    logic [7:0] seed_pat;
    logic [7:0] step_pat;
    logic       step_dir;

    assign tick      = (tick_cnt_q == TICK_LAST);
    assign press     = db & ~db_q;
    assign short_acc = (state_q == StPressed) & ~db;
    // Release has priority over a threshold tick in the same cycle.
    assign long_acc  = (state_q == StPressed) & db & tick & (hold_cnt_q == HOLD_LAST);
    assign next_mode = mode + 2'd1;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tick_cnt_q <= '0;
            db_q       <= 1'b1;
        end else begin
            tick_cnt_q <= tick ? '0 : tick_cnt_q + TW'(1);
            db_q       <= db;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= StIdle;
            hold_cnt_q <= '0;
            ev_short   <= 1'b0;
            ev_long    <= 1'b0;
        end else begin
            ev_short <= short_acc;
            ev_long  <= long_acc;
            unique case (state_q)
                StIdle: begin
                    if (press) begin
                        state_q    <= StPressed;
                        hold_cnt_q <= '0;
                    end
                end
                StPressed: begin
                    if (short_acc) begin
                        state_q <= StIdle;
                    end else if (long_acc) begin
                        state_q <= StLongHeld;
                    end else if (tick) begin
                        hold_cnt_q <= hold_cnt_q + HW'(1);
                    end
                end
                StLongHeld: begin
                    if (!db) state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    always_comb begin
        seed_pat = 8'h01;
        unique case (next_mode)
            2'd1:    seed_pat = 8'h80;
            2'd3:    seed_pat = 8'h00;
            default: seed_pat = 8'h01;
        endcase
    end

    always_comb begin
        step_pat = pattern_q;
        step_dir = dir_left_q;
        unique case (mode)
            2'd0: step_pat = {pattern_q[6:0], pattern_q[7]};
            2'd1: step_pat = {pattern_q[0], pattern_q[7:1]};
            2'd2: begin
                // Turn around on the end LED so each end shows exactly once per sweep.
                if (dir_left_q) begin
                    if (pattern_q[7]) begin
                        step_pat = pattern_q >> 1;
                        step_dir = 1'b0;
                    end else begin
                        step_pat = pattern_q << 1;
                    end
                end else begin
                    if (pattern_q[0]) begin
                        step_pat = pattern_q << 1;
                        step_dir = 1'b1;
                    end else begin
                        step_pat = pattern_q >> 1;
                    end
                end
            end
            default: step_pat = (pattern_q == 8'hFF) ? 8'h00 : {pattern_q[6:0], 1'b1};
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pattern_q  <= 8'h01;
            mode       <= 2'd0;
            running    <= 1'b1;
            dir_left_q <= 1'b1;
            step_cnt_q <= '0;
        end else if (short_acc) begin
            mode       <= next_mode;
            pattern_q  <= seed_pat;
            dir_left_q <= 1'b1;
            step_cnt_q <= '0;
        end else if (long_acc) begin
            running    <= ~running;
            step_cnt_q <= '0;
        end else if (running && tick) begin
            if (step_cnt_q == STEP_LAST) begin
                step_cnt_q <= '0;
                pattern_q  <= step_pat;
                dir_left_q <= step_dir;
            end else begin
                step_cnt_q <= step_cnt_q + SW'(1);
            end
        end
    end

`ifdef PAUSE_BLINK_EN
    logic          blink_q;
    logic [SW-1:0] blink_cnt_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            blink_q     <= 1'b1;
            blink_cnt_q <= '0;
        end else if (running) begin
            blink_q     <= 1'b1;
            blink_cnt_q <= '0;
        end else if (tick) begin
            if (blink_cnt_q == STEP_LAST) begin
                blink_cnt_q <= '0;
                blink_q     <= ~blink_q;
            end else begin
                blink_cnt_q <= blink_cnt_q + SW'(1);
            end
        end
    end

    assign led = running ? pattern_q : (pattern_q & {8{blink_q}});
`else
    assign led = pattern_q;
`endif

endmodule
